pipe_addsub: RTL

// - Parametrised, pipelined signed add/subtract unit for the Y86 execute stage.
// - Successor to the combinational 64-bit ripple adder: width is generic, carry is split into

---
 rtl/pipe_addsub_pkg.sv | 21 ++
 rtl/pipe_addsub_if.sv | 30 +++
 rtl/pipe_addsub_slice.sv | 23 ++
 rtl/pipe_addsub.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: opcode encoding,
// condition-flag bit positions and the carry-into-MSB helper.
package pipe_addsub_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   localparam int FLAG_ZF   = 0;
   localparam int FLAG_SF   = 1;
   localparam int FLAG_OF   = 2;
   localparam int FLAG_CF   = 3;
   localparam int NUM_FLAGS = 4;

   // The carry into a bit position is recoverable from its two addend bits and its sum bit.
   function automatic logic carry_into_msb(input logic a_msb, input logic b_msb, input logic sum_msb);
      return a_msb ^ b_msb ^ sum_msb;
   endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle for pipe_addsub; the unit itself uses the
// slave modport, whoever feeds and drains it uses master.
interface pipe_addsub_if #(
   parameter int WIDTH = 64
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zf;
   logic             sf;
   logic             of;
   logic             cf;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, zf, sf, of, cf
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, zf, sf, of, cf
   );

endinterface

// File: rtl/pipe_addsub_slice.sv
// One CHUNK-bit combinational slice of the pipelined adder; also reports the
// carry into its top bit so the final slice can derive signed overflow.
module pipe_addsub_slice
   import pipe_addsub_pkg::*;
#(
   parameter int CHUNK = 16
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [CHUNK:0] total;

   assign total    = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
   assign sum      = total[CHUNK-1:0];
   assign cout     = total[CHUNK];
   assign c_msb_in = carry_into_msb(a[CHUNK-1], b[CHUNK-1], total[CHUNK-1]);

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined signed add/subtract unit: one CHUNK-bit slice per stage, carry
// rippling through stage registers, valid/ready on both sides, ZF/SF/OF/CF flags.
module pipe_addsub
   import pipe_addsub_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input logic          clk,
   input logic          rst,
   pipe_addsub_if.slave bus
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_check
      $error("pipe_addsub: WIDTH (%0d) must be >= 2 and a multiple of CHUNK (%0d)", WIDTH, CHUNK);
   end

   logic             stall;
   logic             advance;
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;

   // The whole pipe freezes as one while the consumer refuses a valid result.
   assign stall        = bus.out_valid && !bus.out_ready;
   assign advance      = !stall;
   assign bus.in_ready = advance;

   // Subtraction is a + ~b + 1: invert B up front and feed the +1 as stage-0 carry-in.
   assign is_sub = (bus.op == OP_SUB);
   assign b_eff  = is_sub ? ~bus.b : bus.b;

   for (genvar k = 0; k < STAGES; k++) begin : stg
      localparam int DONE = (k + 1) * CHUNK;

      logic [CHUNK-1:0] sa;
      logic [CHUNK-1:0] sb;
      logic [CHUNK-1:0] s;
      logic             sc;
      logic             co;
      logic             c_msb_in;
      logic             vld_d;
      logic             vld_q;
      logic [DONE-1:0]  sum_d;
      logic [DONE-1:0]  sum_q;

      if (k == 0) begin : src
         assign sa    = bus.a[CHUNK-1:0];
         assign sb    = b_eff[CHUNK-1:0];
         assign sc    = is_sub;
         assign vld_d = bus.in_valid;
         assign sum_d = s;
      end else begin : src
         assign sa    = stg[k-1].skew.a_q[CHUNK-1:0];
         assign sb    = stg[k-1].skew.b_q[CHUNK-1:0];
         assign sc    = stg[k-1].skew.carry_q;
         assign vld_d = stg[k-1].vld_q;
         assign sum_d = {s, stg[k-1].sum_q};
      end

      pipe_addsub_slice #(
         .CHUNK (CHUNK)
      ) u_slice (
         .a        (sa),
         .b        (sb),
         .cin      (sc),
         .sum      (s),
         .cout     (co),
         .c_msb_in (c_msb_in)
      );

      // Completed low bits accumulate here; the stage width grows by CHUNK each step.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= 1'b0;
            sum_q <= '0;
         end else if (advance) begin
            vld_q <= vld_d;
            sum_q <= sum_d;
         end
      end

      if (k < LAST) begin : skew
         localparam int REM = WIDTH - DONE;

         logic [REM-1:0] a_d;
         logic [REM-1:0] b_d;
         logic [REM-1:0] a_q;
         logic [REM-1:0] b_q;
         logic           carry_q;
         logic           unused_cmsb;

         assign unused_cmsb = c_msb_in;

         if (k == 0) begin : from_bus
            assign a_d = bus.a[WIDTH-1:CHUNK];
            assign b_d = b_eff[WIDTH-1:CHUNK];
         end else begin : from_prev
            assign a_d = stg[k-1].skew.a_q[REM+CHUNK-1:CHUNK];
            assign b_d = stg[k-1].skew.b_q[REM+CHUNK-1:CHUNK];
         end

         // Untouched upper operand slices travel alongside their partial sum.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q     <= '0;
               b_q     <= '0;
               carry_q <= 1'b0;
            end else if (advance) begin
               a_q     <= a_d;
               b_q     <= b_d;
               carry_q <= co;
            end
         end
      end else begin : last
         logic [NUM_FLAGS-1:0] flags_d;
         logic [NUM_FLAGS-1:0] flags_q;

         always_comb begin
            flags_d          = '0;
            flags_d[FLAG_ZF] = (sum_d == '0);
            flags_d[FLAG_SF] = s[CHUNK-1];
            flags_d[FLAG_OF] = c_msb_in ^ co;
            flags_d[FLAG_CF] = co;
         end

         // Flags are registered rather than decoded from the result so they read 0 after reset.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               flags_q <= '0;
            end else if (advance) begin
               flags_q <= flags_d;
            end
         end
      end
   end

   assign bus.out_valid = stg[LAST].vld_q;
   assign bus.result    = stg[LAST].sum_q;
   assign bus.zf        = stg[LAST].last.flags_q[FLAG_ZF];
   assign bus.sf        = stg[LAST].last.flags_q[FLAG_SF];
   assign bus.of        = stg[LAST].last.flags_q[FLAG_OF];
   assign bus.cf        = stg[LAST].last.flags_q[FLAG_CF];

endmodule
